// File: rtl/dual_port_ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM and its clear sequencer.
package dual_port_ram_pkg;

    localparam int unsigned LANE_WIDTH = 8;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    typedef enum logic {
        INIT,
        READY
    } init_state_e;

    // One byte lane of a write merge: enabled lanes take new data, others keep old contents.
    function automatic logic [LANE_WIDTH-1:0] lane_merge(
        input logic [LANE_WIDTH-1:0] old_lane,
        input logic [LANE_WIDTH-1:0] new_lane,
        input logic                  be
    );
        return be ? new_lane : old_lane;
    endfunction

endpackage

// File: rtl/dual_port_ram_init_seq.sv
// Post-reset clear sequencer: walks every address once, requesting a zero write per cycle.
module dual_port_ram_init_seq
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned Addr_Width = 4,
    parameter int unsigned Init_Clear = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy_o,
    output logic                  init_we_o,
    output logic [Addr_Width-1:0] init_addr_o
);

    init_state_e           state_q, state_d;
    logic [Addr_Width-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (Init_Clear != 0) ? INIT : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we_o = 1'b0;
        unique case (state_q)
            INIT: begin
                init_we_o = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // The last word is written on the same edge that leaves INIT.
                if (cnt_q == {Addr_Width{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign init_busy_o = (state_q == INIT);
    assign init_addr_o = cnt_q;

endmodule

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte-lane writes, read valid handshake, 1- or 2-cycle read latency,
// selectable read-during-write result and an optional post-reset clear.
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned Data_Width   = 32,
    parameter int unsigned Addr_Width   = 4,
    parameter int unsigned Read_Latency = 1,
    parameter int unsigned RDW_Mode     = 0,
    parameter int unsigned Init_Clear   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         init_busy,
    input  logic                         wr_ena,
    input  logic [Data_Width/8-1:0]      wr_be,
    input  logic [Addr_Width-1:0]        Wr_addr,
    input  logic [Data_Width-1:0]        Data_write,
    input  logic                         re_ena,
    input  logic [Addr_Width-1:0]        Re_addr,
    output logic [Data_Width-1:0]        Data_read,
    output logic                         rd_valid
);

    localparam int unsigned NumLanes = Data_Width / LANE_WIDTH;
    localparam int unsigned Depth    = 2 ** Addr_Width;

    if ((Data_Width == 0) || (Data_Width % LANE_WIDTH != 0)) begin : g_bad_width
        $error("dual_port_ram_be: Data_Width must be a positive multiple of 8");
    end
    if ((Read_Latency != 1) && (Read_Latency != 2)) begin : g_bad_latency
        $error("dual_port_ram_be: Read_Latency must be 1 or 2");
    end

    logic                  init_we;
    logic [Addr_Width-1:0] init_addr;

    dual_port_ram_init_seq #(
        .Addr_Width (Addr_Width),
        .Init_Clear (Init_Clear)
    ) u_init_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_busy_o (init_busy),
        .init_we_o   (init_we),
        .init_addr_o (init_addr)
    );

    logic [Data_Width-1:0] mem_q [Depth];

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  mem_we;
    logic [Addr_Width-1:0] mem_addr;
    logic [NumLanes-1:0]   mem_be;
    logic [Data_Width-1:0] mem_wdata;

    assign wr_fire = wr_ena && !init_busy;
    assign rd_fire = re_ena && !init_busy;

    // The clear sequencer owns the write port while it runs; writes during reset are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = Wr_addr;
        mem_be    = wr_be;
        mem_wdata = Data_write;
        if (init_we) begin
            mem_we    = 1'b1;
            mem_addr  = init_addr;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(NumLanes); i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                        mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    logic [Data_Width-1:0] rd_old;
    logic [Data_Width-1:0] rd_merged;
    logic [Data_Width-1:0] rd_word;
    logic                  rdw_hit;

    assign rd_old  = mem_q[Re_addr];
    assign rdw_hit = wr_fire && (Wr_addr == Re_addr);

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        assign rd_merged[l*LANE_WIDTH +: LANE_WIDTH] = lane_merge(
            rd_old[l*LANE_WIDTH +: LANE_WIDTH],
            Data_write[l*LANE_WIDTH +: LANE_WIDTH],
            wr_be[l]
        );
    end

    // Array reads see pre-edge contents, so old-data mode needs no bypass.
    assign rd_word = ((RDW_Mode == RDW_NEW) && rdw_hit) ? rd_merged : rd_old;

    logic                  s1_vld_q;
    logic [Data_Width-1:0] s1_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (Read_Latency == 2) begin : g_lat2
        logic                  s2_vld_q;
        logic [Data_Width-1:0] s2_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rd_valid  = s2_vld_q;
        assign Data_read = s2_data_q;
    end else begin : g_lat1
        assign rd_valid  = s1_vld_q;
        assign Data_read = s1_data_q;
    end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances (latency 1/old-data, latency 2/new-data) share stimulus
// and are checked every cycle against an array-based reference model.
module tb_dual_port_ram_be;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_ena;
    logic [3:0]    wr_be;
    logic [AW-1:0] Wr_addr;
    logic [DW-1:0] Data_write;
    logic          re_ena;
    logic [AW-1:0] Re_addr;

    logic          busy0, busy1, vld0, vld1;
    logic [DW-1:0] rdata0, rdata1;

    always #5 clk = ~clk;

    dual_port_ram_be #(
        .Data_Width   (DW),
        .Addr_Width   (AW),
        .Read_Latency (1),
        .RDW_Mode     (0),
        .Init_Clear   (1)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_busy  (busy0),
        .wr_ena     (wr_ena),
        .wr_be      (wr_be),
        .Wr_addr    (Wr_addr),
        .Data_write (Data_write),
        .re_ena     (re_ena),
        .Re_addr    (Re_addr),
        .Data_read  (rdata0),
        .rd_valid   (vld0)
    );

    dual_port_ram_be #(
        .Data_Width   (DW),
        .Addr_Width   (AW),
        .Read_Latency (2),
        .RDW_Mode     (1),
        .Init_Clear   (1)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_busy  (busy1),
        .wr_ena     (wr_ena),
        .wr_be      (wr_be),
        .Wr_addr    (Wr_addr),
        .Data_write (Data_write),
        .re_ena     (re_ena),
        .Re_addr    (Re_addr),
        .Data_read  (rdata1),
        .rd_valid   (vld1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    int          init_left;
    logic        ev0, ev1, pend_v;
    logic [31:0] ed0, ed1, pend_d;

    function automatic logic [31:0] merge_m(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m = m | (32'hFF << (8 * i));
        end
        return (o & ~m) | (n & m);
    endfunction

    task automatic tick();
        logic        busy, fire, wfire;
        logic [31:0] old_w, new_w;
        @(posedge clk);
        busy  = (init_left > 0);
        fire  = re_ena && !busy;
        wfire = wr_ena && !busy;
        old_w = mem_m[Re_addr];
        new_w = old_w;
        if (wfire && (Wr_addr == Re_addr)) new_w = merge_m(old_w, Data_write, wr_be);
        if (busy) begin
            mem_m[DEPTH - init_left] = 32'h0;
            init_left--;
        end else if (wfire) begin
            mem_m[Wr_addr] = merge_m(mem_m[Wr_addr], Data_write, wr_be);
        end
        ev0 = fire;
        if (fire) ed0 = old_w;
        ev1 = pend_v;
        if (pend_v) ed1 = pend_d;
        pend_v = fire;
        pend_d = new_w;
        #1;
        check_eq("busy0", 32'(busy0), 32'(init_left > 0));
        check_eq("busy1", 32'(busy1), 32'(init_left > 0));
        check_eq("vld0", 32'(vld0), 32'(ev0));
        check_eq("vld1", 32'(vld1), 32'(ev1));
        check_eq("data0", rdata0, ed0);
        check_eq("data1", rdata1, ed1);
    endtask

    task automatic op(input logic we, input logic [3:0] be, input logic [AW-1:0] wa,
                      input logic [31:0] wd, input logic re, input logic [AW-1:0] ra);
        wr_ena     = we;
        wr_be      = be;
        Wr_addr    = wa;
        Data_write = wd;
        re_ena     = re;
        Re_addr    = ra;
        tick();
    endtask

    task automatic idle();
        op(1'b0, 4'h0, '0, 32'h0, 1'b0, '0);
    endtask

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        #1;
        ev0 = 1'b0; ev1 = 1'b0; pend_v = 1'b0;
        ed0 = 32'h0; ed1 = 32'h0;
        check_eq("rst_vld0", 32'(vld0), 32'h0);
        check_eq("rst_vld1", 32'(vld1), 32'h0);
        check_eq("rst_data0", rdata0, 32'h0);
        check_eq("rst_data1", rdata1, 32'h0);
        check_eq("rst_busy0", 32'(busy0), 32'h1);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        init_left = DEPTH;
    endtask

    logic [AW-1:0] wa_r, ra_r;
    int            busy_cycles;

    initial begin
        rst_n = 1'b1;
        wr_ena = 1'b0; wr_be = 4'h0; Wr_addr = '0; Data_write = 32'h0;
        re_ena = 1'b0; Re_addr = '0;
        init_left = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        #2;
        apply_reset(2);

        // Requests during init must be ignored; also count the busy window.
        busy_cycles = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy0) busy_cycles++;
            op(1'b1, 4'hF, 4'd0, 32'hDEADBEEF, 1'b1, 4'd0);
        end
        check_eq("init_len", 32'(busy_cycles), 32'd16);
        op(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'd0);
        check_eq("init_addr0_zero", rdata0, 32'h0);

        for (int a = 0; a < DEPTH; a++) op(1'b0, 4'h0, '0, 32'h0, 1'b1, AW'(a));
        idle();
        idle();

        // Byte-lane write
        op(1'b1, 4'b1111, 4'd3, 32'hAABBCCDD, 1'b0, '0);
        op(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, '0);
        op(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'd3);
        check_eq("be_merge0", rdata0, 32'hAA22CC44);
        idle();
        check_eq("be_merge1", rdata1, 32'hAA22CC44);

        // Read-during-write, same address
        op(1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0, '0);
        op(1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
        check_eq("rdw_old", rdata0, 32'h12345678);
        idle();
        check_eq("rdw_new", rdata1, 32'h1234FFFF);

        // Latency-2 streaming
        for (int a = 0; a < 4; a++) op(1'b1, 4'hF, AW'(a), 32'h10 + 32'(a), 1'b0, '0);
        op(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'd0);
        check_eq("l2_gap", 32'(vld1), 32'h0);
        for (int a = 1; a < 5; a++) begin
            if (a < 4) op(1'b0, 4'h0, '0, 32'h0, 1'b1, AW'(a));
            else idle();
            check_eq("l2_stream_vld", 32'(vld1), 32'h1);
            check_eq("l2_stream_data", rdata1, 32'h10 + 32'(a - 1));
        end
        idle();
        check_eq("l2_stream_end", 32'(vld1), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            wa_r = AW'($urandom_range(0, DEPTH - 1));
            ra_r = ($urandom_range(0, 3) == 0) ? wa_r : AW'($urandom_range(0, DEPTH - 1));
            op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa_r, $urandom,
               1'($urandom_range(0, 1)), ra_r);
        end

        // Reset with reads in flight
        op(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'd1);
        op(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'd2);
        wr_ena = 1'b0; re_ena = 1'b0;
        apply_reset(1);
        for (int i = 0; i < DEPTH; i++) idle();
        check_eq("reinit_done", 32'(busy0), 32'h0);
        for (int a = 0; a < DEPTH; a++) op(1'b0, 4'h0, '0, 32'h0, 1'b1, AW'(a));
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
